// File: rtl/spi_master.sv
// spi_master: memory-mapped mode-0 SPI master (DATA / STATUS / CTRL registers).
// One byte per transfer, MSB first, SCLK half-period of div+1 clocks,
// chip select driven only by software through CTRL.csn.
module spi_master #(
    parameter logic [7:0] RESET_DIV = 8'd15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out,
    output logic        spi_clk_out,
    output logic        spi_csn_out,
    output logic        spi_mosi_out,
    input  logic        spi_miso_in
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    localparam logic [1:0] IDX_DATA   = 2'd0;
    localparam logic [1:0] IDX_STATUS = 2'd1;
    localparam logic [1:0] IDX_CTRL   = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic [7:0] phase_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic [7:0] rx_byte;
    logic [7:0] div;
    logic       rx_valid;
    logic       csn;
    logic       sclk;
    logic       mosi;
    logic       busy;

    logic [1:0] reg_idx;
    logic       bus_wr;
    logic       data_wr;
    logic       data_rd;
    logic       ctrl_div_wr;
    logic       ctrl_csn_wr;
    logic       phase_done;
    logic       last_bit;
    logic       unused_bits;

    // Bus decode: only address bits [3:2] select a register.
    assign reg_idx     = address_in[3:2];
    assign bus_wr      = sel_in && (write_mask_in != 4'h0);
    assign data_wr     = bus_wr && (reg_idx == IDX_DATA) && write_mask_in[0];
    assign ctrl_div_wr = bus_wr && (reg_idx == IDX_CTRL) && write_mask_in[0];
    assign ctrl_csn_wr = bus_wr && (reg_idx == IDX_CTRL) && write_mask_in[1];
    assign data_rd     = sel_in && read_in && (reg_idx == IDX_DATA);
    assign phase_done  = (phase_cnt == div);
    assign last_bit    = (bit_cnt == 3'd7);
    assign busy        = (state != ST_IDLE);
    assign unused_bits = ^{address_in[31:4], address_in[1:0], write_value_in[31:9], write_mask_in[3:2]};

    // Next-state logic: IDLE -> LOW -> HIGH, eight LOW/HIGH pairs per byte.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (data_wr)    state_next = ST_LOW;
            ST_LOW:  if (phase_done) state_next = ST_HIGH;
            ST_HIGH: if (phase_done) state_next = last_bit ? ST_IDLE : ST_LOW;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Datapath: shifters, counters, SPI pins and software-visible registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_cnt <= 8'd0;
            bit_cnt   <= 3'd0;
            tx_shift  <= 8'd0;
            rx_shift  <= 8'd0;
            rx_byte   <= 8'd0;
            rx_valid  <= 1'b0;
            div       <= RESET_DIV;
            csn       <= 1'b1;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
        end else begin
            if (ctrl_csn_wr) csn <= write_value_in[8];
            // div is frozen while a byte is in flight so the bit timing stays uniform
            if (ctrl_div_wr && !busy) div <= write_value_in[7:0];
            // a DATA read consumes rx_valid; a completing transfer below overrides this
            if (data_rd) rx_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (data_wr) begin
                        tx_shift  <= write_value_in[7:0];
                        mosi      <= write_value_in[7];
                        rx_valid  <= 1'b0;
                        bit_cnt   <= 3'd0;
                        phase_cnt <= 8'd0;
                    end
                end
                ST_LOW: begin
                    if (phase_done) begin
                        sclk      <= 1'b1;
                        rx_shift  <= {rx_shift[6:0], spi_miso_in};
                        phase_cnt <= 8'd0;
                    end else begin
                        phase_cnt <= 8'(phase_cnt + 8'd1);
                    end
                end
                ST_HIGH: begin
                    if (phase_done) begin
                        sclk      <= 1'b0;
                        phase_cnt <= 8'd0;
                        if (last_bit) begin
                            rx_byte  <= rx_shift;
                            rx_valid <= 1'b1;
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            mosi     <= tx_shift[6];
                            bit_cnt  <= 3'(bit_cnt + 3'd1);
                        end
                    end else begin
                        phase_cnt <= 8'(phase_cnt + 8'd1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Zero-latency register read mux, forced to zero when not selected.
    always_comb begin
        read_value_out = 32'h0;
        if (sel_in) begin
            case (reg_idx)
                IDX_DATA:   read_value_out = {24'h0, rx_byte};
                IDX_STATUS: read_value_out = {30'h0, rx_valid, busy};
                IDX_CTRL:   read_value_out = {23'h0, csn, div};
                default:    read_value_out = 32'h0;
            endcase
        end
    end

    assign ready_out    = sel_in;
    assign spi_clk_out  = sclk;
    assign spi_csn_out  = csn;
    assign spi_mosi_out = mosi;

endmodule
